// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers (write and read side).
package fifo_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned PTR_W  = ADDR_W + 1;

  // Both helpers work on any width up to 32 bits, provided narrower values are zero-extended.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side handshake and status bundle of the async FIFO.
// The master modport is the write client; the slave modport is fifo_wr_ctrl.
interface fifo_wr_ctrl_if #(
  parameter int unsigned ADDR_W = fifo_pkg::ADDR_W
) ();
  localparam int unsigned PTR_W = ADDR_W + 1;

  logic              winc;
  logic [PTR_W-1:0]  wq2_rptr;
  logic [ADDR_W-1:0] waddr;
  logic [PTR_W-1:0]  wptr;
  logic              wfull;
  logic              walmost_full;
  logic              woverflow;

  modport master (
    output winc, wq2_rptr,
    input  waddr, wptr, wfull, walmost_full, woverflow
  );

  modport slave (
    input  winc, wq2_rptr,
    output waddr, wptr, wfull, walmost_full, woverflow
  );
endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or
// above it. Shared by the write and read controllers.
module fifo_gray2bin #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] gray_i,
  output logic [Width-1:0] bin_o
);
  for (genvar i = 0; i < Width; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[Width-1:i];
  end
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer/flag controller of the async FIFO.
// Optional sticky overflow flag built only when ASYNC_FIFO_WR_OVF_EN is defined.
module fifo_wr_ctrl #(
  parameter int unsigned ADDR_W    = fifo_pkg::ADDR_W,
  parameter int unsigned AFULL_LVL = 6
) (
  input  logic          wclk,
  input  logic          wrst_n,
  fifo_wr_ctrl_if.slave bus
);
  localparam int unsigned       PTR_W     = ADDR_W + 1;
  localparam logic [PTR_W-1:0]  AFULL_THR = PTR_W'(AFULL_LVL);

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wptr_q, wgray_d;
  logic [PTR_W-1:0] rbin, full_ptr, level;
  logic             wfull_q, wfull_d;
  logic             wafull_q, wafull_d;
  logic             wpush;

  fifo_gray2bin #(
    .Width (PTR_W)
  ) u_rptr_g2b (
    .gray_i (bus.wq2_rptr),
    .bin_o  (rbin)
  );

  always_comb begin
    wpush   = bus.winc & ~wfull_q;
    wbin_d  = wbin_q + {{(PTR_W-1){1'b0}}, wpush};
    wgray_d = PTR_W'(fifo_pkg::bin2gray(32'(wbin_d)));
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_ptr = {~bus.wq2_rptr[PTR_W-1 -: 2], bus.wq2_rptr[PTR_W-3:0]};
    wfull_d  = (wgray_d == full_ptr);
    level    = wbin_d - rbin;
    wafull_d = (level >= AFULL_THR);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wgray_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
    end
  end

`ifdef ASYNC_FIFO_WR_OVF_EN
  logic wovf_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf_q <= 1'b0;
    end else if (bus.winc && wfull_q) begin
      wovf_q <= 1'b1;
    end
  end

  assign bus.woverflow = wovf_q;
`else
  assign bus.woverflow = 1'b0;
`endif

  assign bus.waddr        = wbin_q[ADDR_W-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = wafull_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: occupancy-count model, directed plan, random traffic.
module tb_fifo_wr_ctrl;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned AFULL_LVL = 6;
  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam int unsigned PMOD      = 2 * DEPTH;

  logic wclk;
  logic wrst_n;

  fifo_wr_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  fifo_wr_ctrl #(
    .ADDR_W    (ADDR_W),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: total accepted writes and the reader's position, both modulo 2*depth.
  int unsigned m_wcnt = 0;
  int unsigned rd_bin = 0;
  bit          m_full = 1'b0;
  bit          m_af   = 1'b0;
  bit          m_ovf  = 1'b0;

  function automatic logic [3:0] gray4(input int unsigned b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic bit exp_ovf();
`ifdef ASYNC_FIFO_WR_OVF_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: full means the FIFO holds exactly depth entries; level uses pre-edge read pointer.
  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_wcnt = 0;
      m_full = 1'b0;
      m_af   = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      int unsigned lvl;
      if (bus.winc && m_full) m_ovf = 1'b1;
      if (bus.winc && !m_full) m_wcnt = (m_wcnt + 1) % PMOD;
      lvl    = (m_wcnt + PMOD - rd_bin) % PMOD;
      m_full = (lvl == DEPTH);
      m_af   = (lvl >= AFULL_LVL);
    end
  end

  always @(negedge wclk) begin
    if (chk_en && wrst_n) begin
      chk("waddr", bus.waddr, m_wcnt % DEPTH);
      chk("wptr", bus.wptr, gray4(m_wcnt));
      chk("wfull", bus.wfull, m_full);
      chk("walmost_full", bus.walmost_full, m_af);
      chk("woverflow", bus.woverflow, exp_ovf());
    end
  end

  task automatic step(input bit w, input int unsigned r);
    bus.winc     = w;
    rd_bin       = r;
    bus.wq2_rptr = gray4(r);
    @(posedge wclk);
    #1;
  endtask

  initial begin
    bus.winc     = 1'b0;
    bus.wq2_rptr = '0;
    wrst_n       = 1'b0;
    #23;
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    chk_en = 1'b1;

    chk("rst_waddr", bus.waddr, 0);
    chk("rst_wptr", bus.wptr, 4'b0000);
    chk("rst_wfull", bus.wfull, 0);
    chk("rst_afull", bus.walmost_full, 0);
    chk("rst_ovf", bus.woverflow, 0);

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 0);
      if (i == 5) chk("afull_after5", bus.walmost_full, 0);
      if (i == 6) chk("afull_after6", bus.walmost_full, 1);
      if (i == 7) chk("full_after7", bus.wfull, 0);
    end
    chk("full_after8", bus.wfull, 1);
    chk("wptr_after8", bus.wptr, 4'b1100);
    chk("waddr_after8", bus.waddr, 0);

    repeat (3) step(1'b1, 0);
    chk("wptr_blocked", bus.wptr, 4'b1100);
    chk("waddr_blocked", bus.waddr, 0);
`ifdef ASYNC_FIFO_WR_OVF_EN
    chk("ovf_set", bus.woverflow, 1);
`else
    chk("ovf_tied", bus.woverflow, 0);
`endif

    step(1'b0, 1);
    chk("full_release", bus.wfull, 0);
    chk("afull_hold", bus.walmost_full, 1);
    step(1'b1, 1);
    chk("refull", bus.wfull, 1);
    chk("wptr_refull", bus.wptr, 4'b1101);

    step(1'b0, 8);
    repeat (7) step(1'b1, 8);
    chk("wrap_wptr", bus.wptr, 4'b0000);
    chk("wrap_full", bus.wfull, 1);

    // Asynchronous reset while full, checked before any further clock edge.
    step(1'b1, 8);
    wrst_n = 1'b0;
    #1;
    chk("arst_waddr", bus.waddr, 0);
    chk("arst_wptr", bus.wptr, 0);
    chk("arst_wfull", bus.wfull, 0);
    chk("arst_afull", bus.walmost_full, 0);
    chk("arst_ovf", bus.woverflow, 0);
    bus.winc     = 1'b0;
    rd_bin       = 0;
    bus.wq2_rptr = '0;
    @(negedge wclk);
    wrst_n = 1'b1;
    step(1'b1, 0);
    chk("post_rst_waddr", bus.waddr, 1);
    chk("post_rst_wptr", bus.wptr, 4'b0001);

    // Random traffic in phases biased toward filling, draining and balance.
    for (int ph = 0; ph < 6; ph++) begin
      int unsigned wp, rp;
      wp = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 20 : 60;
      rp = (ph % 3 == 0) ? 15 : (ph % 3 == 1) ? 85 : 55;
      for (int c = 0; c < 300; c++) begin
        int unsigned r;
        bit w;
        r = rd_bin;
        if (r != m_wcnt && $urandom_range(99) < rp) r = (r + 1) % PMOD;
        w = ($urandom_range(99) < wp);
        step(w, r);
      end
    end

    step(1'b0, rd_bin);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
